decoder_5_32_strobe: RTL and testbench
======================================

Name: decoder_5_32_strobe

Overview:
- Registered 5-to-32 decoder: the inverse of the team's 32-to-5 priority encoder.
- Accepts a 5-bit index over a valid/ready handshake.
- Drives the matching one-hot line on a 32-bit strobe bus for a programmable number of cycles, then returns the bus to zero.
- Sits between control logic that produces bit indices and the 32 per-channel select/strobe lines.

Parameters:
- HOLD_CYCLES, 4, cycles each accepted code is held on out; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  block enable; 0 blocks acceptance and aborts an active hold.
- in_valid  input  1  code present on in.
- in_ready  output  1  block can accept a code this cycle.
- in  input  5  bit index 0..31.
- out  output  32  one-hot strobe bus, registered.
- out_valid  output  1  out currently carries a held code, registered.
- busy  output  1  state is HOLD.

Behaviour:
- Reset (async, immediate): out=0, out_valid=0, busy=0, counter=0, state=IDLE. in_ready is combinational and follows the rules below once rst deasserts.
- States: IDLE and HOLD.
- in_ready = en & (state==IDLE | (state==HOLD & cnt==0)).
- Accept = in_valid & in_ready.
- IDLE:
  - On accept, next edge: out = 32'b1 << in, out_valid=1, cnt=HOLD_CYCLES-1, state=HOLD.
  - Latency: one cycle from accept to out.
  - Without accept: out stays 0.
- HOLD, cnt>0, en=1:
  - cnt decrements each cycle; out is unchanged.
  - in_ready=0; in and in_valid are ignored.
- HOLD, cnt==0 (last hold cycle):
  - With accept: out loads the new one-hot code and cnt reloads to HOLD_CYCLES-1, with no zero gap (back-to-back).
  - Without accept: next edge out=0, out_valid=0, state=IDLE.
- HOLD_CYCLES=1: every code is held exactly one cycle. Sustained in_valid gives one code per cycle.
- en=0:
  - in_ready=0.
  - If in HOLD, next edge: out=0, out_valid=0, state=IDLE (abort).
  - Codes presented while en=0 are never accepted.
- Exactly one bit of out is set whenever out_valid=1; out==0 whenever out_valid=0.
- in is 5 bits, so every value decodes; there is no invalid index.
- Reset asserted mid-hold clears all outputs immediately, without waiting for a clock edge.

Optional Feature:
- Macro: DECODER_THERMO_EN.
- Defined:
  - Adds input port thermo (1 bit), sampled at accept and held with the code.
  - thermo=1 loads out = (32'b1 << (in+1)) - 1, i.e. bits 0..in set; in=31 gives all ones.
  - thermo=0 gives normal one-hot output.
  - The one-hot invariant applies only to thermo=0 codes.
- Undefined: the thermo port does not exist; output is always one-hot.

Decomposition:
- Package decoder_pkg holds:
  - IDX_W=5, N_OUT=32.
  - State enum {IDLE, HOLD}.
  - Function onehot(idx).
  - Function thermo(idx) (under macro).
- One sub-module, dec_5_32_comb: purely combinational index to one-hot (and thermometer, when the macro is defined). The top level owns the FSM, counter and registers.

Test Plan:
- Reset then HOLD_CYCLES=4, en=1, one accept of in=5 -> out=32'h0000_0020, out_valid=1 for exactly 4 cycles starting one cycle after accept, then out=0.
- Back-to-back: in=0 then in=31 with in_valid held high -> out=32'h1 for 4 cycles, then 32'h8000_0000 on the next cycle with no zero gap; in_ready high only in IDLE and in the cnt==0 cycle.
- Abort: accept in=12, drop en in the 2nd hold cycle -> out=0, out_valid=0 on the next edge; in_valid held during en=0 is never accepted.
- Async reset mid-hold: assert rst between clock edges -> out=0, busy=0 immediately; first accept after release behaves normally.
- HOLD_CYCLES=1 sweep of in=0..31 with continuous valid -> out walks 1<<k, one code per cycle, with popcount(out)==1 every cycle.
- DECODER_THERMO_EN defined, thermo=1, in=3 -> out=32'h0000_000F; in=31 -> 32'hFFFF_FFFF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths, FSM state type and decode helpers for the 5-to-32 strobe decoder.
// DECODER_THERMO_EN adds the thermometer helper.
package decoder_pkg;

    localparam int IDX_W = 5;
    localparam int N_OUT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_OUT-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_OUT'(1) << idx;
    endfunction

`ifdef DECODER_THERMO_EN
    // Bits 0..idx set; idx=31 yields all ones.
    function automatic logic [N_OUT-1:0] thermo(input logic [IDX_W-1:0] idx);
        return {N_OUT{1'b1}} >> (N_OUT - 1 - int'(idx));
    endfunction
`endif

endpackage

// File: rtl/dec_5_32_comb.sv
// Index to one-hot (or thermometer with DECODER_THERMO_EN) decode.
// Purely combinational, zero latency; no flow control.
// Every 5-bit index is legal, so there is no error output.
module dec_5_32_comb
    import decoder_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
`ifdef DECODER_THERMO_EN
    input  logic             thermo_sel,
`endif
    output logic [N_OUT-1:0] dec
);

    always_comb begin
        dec = onehot(idx);
`ifdef DECODER_THERMO_EN
        if (thermo_sel) begin
            dec = thermo(idx);
        end
`endif
    end

endmodule

// File: rtl/decoder_5_32_strobe.sv
// Registered 5-to-32 strobe decoder; holds each accepted code on out for HOLD_CYCLES cycles.
// Latency: out updates one cycle after accept; back-to-back codes leave no zero gap.
// Backpressure: in_ready only when idle or in the last hold cycle; en=0 blocks and aborts. Option: DECODER_THERMO_EN.
module decoder_5_32_strobe
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in,
`ifdef DECODER_THERMO_EN
    input  logic             thermo,
`endif
    output logic [N_OUT-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_OUT-1:0]   out_d;
    logic               out_valid_d;
    logic [N_OUT-1:0]   dec_word;
    logic               accept;

    dec_5_32_comb u_dec (
        .idx        (in),
`ifdef DECODER_THERMO_EN
        .thermo_sel (thermo),
`endif
        .dec        (dec_word)
    );

    // cnt==0 marks the last hold cycle, where a new code may chain in without a gap.
    assign in_ready = en && ((state_q == IDLE) || (cnt_q == '0));
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == HOLD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out;
        out_valid_d = out_valid;
        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            state_d     = HOLD;
            cnt_d       = HOLD_M1;
            out_d       = dec_word;
            out_valid_d = 1'b1;
        end else if (state_q == HOLD) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d     = IDLE;
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out       <= out_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_decoder_5_32_strobe.sv
// Scoreboard bench: two decoders (hold 4 and hold 1) share one randomized/directed stimulus stream.
module tb_decoder_5_32_strobe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in = '0;
    logic        thermo_i = 1'b0;
    logic [1:0]  rdy, ovld, bsy;
    logic [31:0] dout [2];

    logic [31:0] exp_q [2][$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    decoder_5_32_strobe #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[0]), .in(in),
`ifdef DECODER_THERMO_EN
        .thermo(thermo_i),
`endif
        .out(dout[0]), .out_valid(ovld[0]), .busy(bsy[0])
    );

    decoder_5_32_strobe #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[1]), .in(in),
`ifdef DECODER_THERMO_EN
        .thermo(thermo_i),
`endif
        .out(dout[1]), .out_valid(ovld[1]), .busy(bsy[1])
    );

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Reference: a code accepted now is shown for exactly hold_of(k) future cycles;
    // the queue holds the words still owed, so the block is ready only when nothing is owed.
    task automatic cycle(input logic e, input logic v, input logic [4:0] idx, input logic th);
        logic        rdy_m;
        logic [31:0] word;
        @(negedge clk);
        en = e; in_valid = v; in = idx; thermo_i = th;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy_m = e && (exp_q[k].size() == 0);
            check("in_ready", k, {31'b0, rdy[k]}, {31'b0, rdy_m});
            if (!e) begin
                exp_q[k].delete();
            end else if (v && rdy_m) begin
                word = th ? 32'((64'd1 << (idx + 1)) - 64'd1) : 32'(64'd1 << idx);
                repeat (hold_of(k)) exp_q[k].push_back(word);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic mid_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_out", k, dout[k], 32'h0);
            check("rst_out_valid", k, {31'b0, ovld[k]}, 32'h0);
            check("rst_busy", k, {31'b0, bsy[k]}, 32'h0);
            exp_q[k].delete();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every cycle, out must show the owed word (or zero when nothing is owed).
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] e;
            logic        ev;
            if (exp_q[k].size() > 0) begin
                e  = exp_q[k].pop_front();
                ev = 1'b1;
            end else begin
                e  = 32'h0;
                ev = 1'b0;
            end
            check("out", k, dout[k], e);
            check("out_valid", k, {31'b0, ovld[k]}, {31'b0, ev});
            check("busy", k, {31'b0, bsy[k]}, {31'b0, ev});
`ifndef DECODER_THERMO_EN
            if (ev) check("popcount", k, $countones(dout[k]), 32'd1);
`endif
        end
    end

    initial begin
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_out", k, dout[k], 32'h0);
            check("reset_out_valid", k, {31'b0, ovld[k]}, 32'h0);
            check("reset_busy", k, {31'b0, bsy[k]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single accept of index 5.
        cycle(1'b1, 1'b1, 5'd5, 1'b0);
        idle(6);

        // Back-to-back 0 then 31 with valid held high.
        cycle(1'b1, 1'b1, 5'd0, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 5'd31, 1'b0);
        idle(6);

        // Abort in the second hold cycle; valid held while disabled.
        cycle(1'b1, 1'b1, 5'd12, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 5'd7, 1'b0);
        idle(5);

        // Asynchronous reset mid-hold, then a normal accept.
        cycle(1'b1, 1'b1, 5'd9, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 1'b0);
        mid_reset();
        cycle(1'b1, 1'b1, 5'd17, 1'b0);
        idle(5);

        // Continuous-valid sweep of every index.
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 5'(i), 1'b0);
        idle(5);

`ifdef DECODER_THERMO_EN
        cycle(1'b1, 1'b1, 5'd3, 1'b1);
        idle(5);
        cycle(1'b1, 1'b1, 5'd31, 1'b1);
        idle(5);
`endif

        for (int i = 0; i < 400; i++) begin
            logic th;
`ifdef DECODER_THERMO_EN
            th = 1'($urandom_range(0, 1));
`else
            th = 1'b0;
`endif
            cycle(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), th);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
